// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the 4-lane data memory; latency store beats+1, load 3, error 1; single outstanding request, ready only in IDLE.
// Build option LSU_MISALIGN_TRAP_EN: any non-naturally-aligned access errors instead of splitting in-word halfwords.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wd,
  output logic [3:0]        o_mem_wen,
  output logic              o_mem_ren,
  input  logic [DATA_W-1:0] i_mem_rd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RDCAP = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [3:0]        rem_q;

  logic [1:0]        off;
  logic              illegal;
  logic              misal;
  logic [3:0]        size_mask;
  logic [3:0]        req_mask;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0111, 4'b1111: mask_legal = 1'b1;
      default:                   mask_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lowest(input logic [3:0] m);
    lowest = m & (~m + 4'd1);
  endfunction

  always_comb begin
    off = i_req_addr[1:0];
    if (i_req_we)
      illegal = i_req_funct3[2] | (i_req_funct3[1:0] == 2'b11);
    else
      illegal = (i_req_funct3[1:0] == 2'b11) | (i_req_funct3[2] & i_req_funct3[1]);
    case (i_req_funct3[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misal = ((i_req_funct3[1:0] == 2'd1) && off[0]) ||
            ((i_req_funct3[1:0] == 2'd2) && (off != 2'd0));
`else
    // Only word-crossing accesses fault; in-word halfwords at offset 1 are split.
    misal = ((i_req_funct3[1:0] == 2'd1) && (off == 2'd3)) ||
            ((i_req_funct3[1:0] == 2'd2) && (off != 2'd0));
`endif
    req_mask = size_mask << off;
  end

  always_comb begin
    rd_shift = i_mem_rd >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    rd_ext = {24'd0, rd_shift[7:0]};
      3'd5:    rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      rem_q       <= 4'd0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
      o_mem_addr  <= '0;
      o_mem_wd    <= '0;
      o_mem_wen   <= 4'd0;
      o_mem_ren   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            f3_q        <= i_req_funct3;
            off_q       <= off;
            if (illegal || misal) begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else if (i_req_we) begin
              state      <= S_WR;
              o_mem_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
              o_mem_wd   <= i_req_wdata << {off, 3'b000};
              // Masks the memory cannot take are issued one lane per beat, low lane first.
              if (mask_legal(req_mask)) begin
                o_mem_wen <= req_mask;
                rem_q     <= 4'd0;
              end else begin
                o_mem_wen <= lowest(req_mask);
                rem_q     <= req_mask & ~lowest(req_mask);
              end
            end else begin
              state      <= S_RD;
              o_mem_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
              o_mem_ren  <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (rem_q != 4'd0) begin
            o_mem_wen <= lowest(rem_q);
            rem_q     <= rem_q & ~lowest(rem_q);
          end else begin
            o_mem_wen   <= 4'd0;
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
          end
        end
        S_RD: begin
          o_mem_ren <= 1'b0;
          state     <= S_RDCAP;
        end
        S_RDCAP: begin
          o_rsp_rdata <= rd_ext;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          state       <= S_RESP;
        end
        S_RESP: begin
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_req_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_mem_wen   <= 4'd0;
          o_mem_ren   <= 1'b0;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that drives the byte-lane data memory on behalf of the RV32 pipeline.
- Accepts one load or store request at a time over a valid/ready handshake, decoded by funct3.
- Generates the word address, lane-aligned write data, write-enable mask and read-enable for the memory.
- Extracts and sign/zero-extends load data, and returns a single-cycle response.
- The memory honours only the write masks 0001, 0010, 0100, 1000, 0011, 0111 and 1111. Any other required mask is issued as sequential single-byte writes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, 4 byte lanes

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock domain, asynchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1=store, 0=load
- i_req_funct3  in  3  RV32 funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned access or illegal funct3
- o_mem_addr  out  32  {addr[31:2],2'b00}
- o_mem_wd  out  32  store data shifted to its byte lanes, i_req_wdata << (8*addr[1:0])
- o_mem_wen  out  4  byte write mask; only legal masks ever driven
- o_mem_ren  out  1  read enable
- i_mem_rd  in  32  registered memory read data; valid the cycle after o_mem_ren

Behaviour:
- States: IDLE, WR, RD, RDCAP, RESP. All outputs are registered.
- Reset (async, any state): state goes to IDLE. o_rsp_valid, o_rsp_err, o_mem_wen and o_mem_ren go to 0; o_rsp_rdata, o_mem_addr and o_mem_wd go to 0.
- IDLE:
  - o_req_ready=1. The request is captured on i_req_valid&&o_req_ready.
  - Illegal funct3 (load 3/6/7, store 3–7) or a misaligned access: go to RESP with err=1. No memory strobe is driven.
  - Otherwise a load goes to RD and a store goes to WR.
- Misaligned: LH/LHU/SH with addr[1:0]=3, or LW/SW with addr[1:0]≠0, are word-crossing and always errors.
- WR:
  - Beat list is built from the required mask M = size mask << addr[1:0].
  - If M is legal, one beat with wen=M.
  - Otherwise, one single-byte beat per set bit, lowest lane first. Cases: SH@2 gives 0100 then 1000; SH@1 gives 0010 then 0100.
  - Each beat lasts one cycle. o_mem_wd is held constant across all beats.
  - After the last beat, go to RESP.
- RD: one cycle with o_mem_ren=1 and wen=0000, then go to RDCAP.
- RDCAP: sample i_mem_rd, shift right by 8*addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), then go to RESP.
- RESP: o_rsp_valid=1 for exactly one cycle. There is no response backpressure. Next state is IDLE.
- Latency, acceptance edge to o_rsp_valid:
  - store: beats+1 cycles
  - load: 3 cycles
  - error: 1 cycle
- o_mem_wen and o_mem_ren are never high together. Both are 0 in every state except their issue state.
- Throughput: at most one request per (latency+1) cycles. i_req_valid is ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: every non-naturally-aligned access is an error. This covers any halfword with odd addr and any word with addr[1:0]≠0. No memory strobe is driven.
- Undefined: in-word misaligned halfwords (addr[1:0]=1) are performed. Stores use the split beats; loads use a single read. Only word-crossing accesses are errors.

Test Plan:
- Preload mem[0x10]=0x8899AABB; LB 0x13 -> ren one cycle, rsp 3 cycles after accept, rdata=0xFFFFFF88, err=0.
- LHU 0x12 on the same word -> rdata=0x00008899; LH 0x10 -> rdata=0xFFFFAABB.
- SW 0x20, wdata 0xDEADBEEF -> single beat, wen=1111, addr=0x20, rsp after 2 cycles; a readback LW gives 0xDEADBEEF.
- SH 0x12, wdata 0x1234 over word 0x8899AABB -> wen 0100 then 1000, wd=0x12340000 on both beats, rsp after 3 cycles; the word becomes 0x1234AABB.
- LW 0x22 and store funct3=5 -> rsp after 1 cycle, err=1, rdata=0; wen and ren stay 0 throughout.
- SH 0x11, wdata 0xCAFE:
  - macro undefined: beats 0010 then 0100, word gets 0x..CAFE..
  - macro defined: err=1, no write
  - in either case, deassert i_rst_n during the first beat -> wen=0 immediately and ready=1 after release.
